// File: rtl/reg_file_rename.sv
// Architectural register file with per-register busy/ROB-tag rename tracking.
// Optional same-cycle commit-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_rename #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int NUM_READ   = 2,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS),
    localparam int CNT_WIDTH  = $clog2(NUM_REGS + 1)
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           rdy_in,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr_in,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data_out,
    output logic [NUM_READ-1:0]            rd_busy_out,
    output logic [NUM_READ*TAG_WIDTH-1:0]  rd_tag_out,
    input  logic                           rename_en_in,
    input  logic [ADDR_WIDTH-1:0]          rename_addr_in,
    input  logic [TAG_WIDTH-1:0]           rename_tag_in,
    input  logic                           commit_en_in,
    input  logic [ADDR_WIDTH-1:0]          commit_addr_in,
    input  logic [TAG_WIDTH-1:0]           commit_tag_in,
    input  logic [DATA_WIDTH-1:0]          commit_data_in,
    input  logic                           flush_in,
    output logic [CNT_WIDTH-1:0]           busy_count_out
);

    logic [DATA_WIDTH-1:0] value_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] value_d [NUM_REGS];
    logic [TAG_WIDTH-1:0]  tag_q   [NUM_REGS];
    logic [TAG_WIDTH-1:0]  tag_d   [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic commit_ok;
    logic rename_ok;

    assign commit_ok = commit_en_in && (commit_addr_in != '0);
    assign rename_ok = rename_en_in && (rename_addr_in != '0);

    // Commit first, then flush/rename so a same-address rename overrides the busy clear.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (rdy_in) begin
            if (commit_ok) begin
                value_d[commit_addr_in] = commit_data_in;
                if (busy_q[commit_addr_in] && (tag_q[commit_addr_in] == commit_tag_in)) begin
                    busy_d[commit_addr_in] = 1'b0;
                    tag_d[commit_addr_in]  = '0;
                end
            end
            if (flush_in) begin
                busy_d = '0;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    tag_d[i] = '0;
                end
            end else if (rename_ok) begin
                busy_d[rename_addr_in] = 1'b1;
                tag_d[rename_addr_in]  = rename_tag_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] d;
        logic                  b;
        logic [TAG_WIDTH-1:0]  t;
        rd_data_out = '0;
        rd_busy_out = '0;
        rd_tag_out  = '0;
        for (int unsigned p = 0; p < NUM_READ; p++) begin
            a = rd_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH];
            d = '0;
            b = 1'b0;
            t = '0;
            if (a != '0) begin
                d = value_q[a];
                b = busy_q[a];
                t = busy_q[a] ? tag_q[a] : '0;
            end
`ifdef REG_FILE_BYPASS_EN
            if (commit_ok && (commit_addr_in == a)) begin
                d = commit_data_in;
                if (busy_q[a] && (tag_q[a] == commit_tag_in)) begin
                    b = 1'b0;
                    t = '0;
                end
            end
`endif
            rd_data_out[p*DATA_WIDTH +: DATA_WIDTH] = d;
            rd_busy_out[p]                          = b;
            rd_tag_out[p*TAG_WIDTH +: TAG_WIDTH]    = t;
        end
    end

    assign busy_count_out = CNT_WIDTH'($countones(busy_q));

endmodule

// File: doc/reg_file_rename.md
# reg_file_rename

Parametrised architectural register file with per-register rename tracking for the out-of-order core. Holds committed register values, plus a busy bit and a reorder-buffer tag per register. The dispatcher reads it through NUM_READ ports and marks destinations renamed; the reorder buffer writes committed results and clears busy status when tags match. A flush drops all in-flight renames on misprediction.

## Interface
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- DATA_WIDTH, 32, register data width.
- TAG_WIDTH, 4, reorder-buffer tag width.
- NUM_READ, 2, number of independent read ports.
- ADDR_WIDTH, $clog2(NUM_REGS), derived; not to be overridden.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low, no state changes.
- rd_addr_in  input  NUM_READ*ADDR_WIDTH  read addresses, port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data_out  output  NUM_READ*DATA_WIDTH  read data per port.
- rd_busy_out  output  NUM_READ  register renamed and not yet committed.
- rd_tag_out  output  NUM_READ*TAG_WIDTH  ROB tag owning the register; 0 when not busy.
- rename_en_in  input  1  mark rename_addr_in busy with rename_tag_in.
- rename_addr_in  input  ADDR_WIDTH  destination register being renamed.
- rename_tag_in  input  TAG_WIDTH  ROB tag of the renaming instruction.
- commit_en_in  input  1  commit write from the ROB.
- commit_addr_in  input  ADDR_WIDTH  committed destination register.
- commit_tag_in  input  TAG_WIDTH  ROB tag of the committing instruction.
- commit_data_in  input  DATA_WIDTH  committed value.
- flush_in  input  1  misprediction flush; clears all busy bits.
- busy_count_out  output  $clog2(NUM_REGS+1)  number of currently busy registers.

## Operation
- State per register: value, busy, tag. Register 0 always reads value 0, busy 0 and tag 0. Renames and commits to register 0 are ignored.
- Commit (commit_en_in=1, rdy_in=1, addr≠0):
  - The value is always written.
  - busy is cleared only if busy=1 and the stored tag equals commit_tag_in.
  - A stale commit (tag mismatch) writes the value and leaves busy and tag unchanged.
- Rename (rename_en_in=1, rdy_in=1, flush_in=0, addr≠0): busy←1, tag←rename_tag_in.
- Rename and commit to the same address in the same cycle: the data write occurs and the rename wins, so busy=1 and tag=rename_tag_in.
- Flush: all busy bits←0 and all tags←0. A same-cycle commit still writes its value. A same-cycle rename is discarded.
- Reads are combinational from current state. Same-cycle renames are not visible to reads.
- busy_count_out is the combinational popcount of the busy vector.
- rdy_in=0 freezes all state; reads remain valid.

## Timing
- Reset (rst_n_in low, asynchronous) sets every value, busy bit and tag to 0. Consequently, immediately after reset: rd_data_out=0, rd_busy_out=0, rd_tag_out=0 and busy_count_out=0.
- Read latency is 0 cycles (combinational).
- Update latency is 1 cycle: a commit or rename is visible on reads the cycle after the edge.
- Reset asserted mid-operation discards all pending renames and values immediately, without waiting for a clock edge.

## Configuration
- REG_FILE_BYPASS_EN defined: a read port whose address equals commit_addr_in while commit_en_in=1 and addr≠0 behaves as follows:
  - rd_data_out returns commit_data_in in the same cycle.
  - If the commit tag matches the stored tag, rd_busy_out=0 and rd_tag_out=0.
  - Bypass is independent of rdy_in and flush_in.
- REG_FILE_BYPASS_EN undefined: reads return stored state only, and the committed value appears one cycle later.

## Test plan
- Reset, then read registers 0–31 on both ports -> all data 0, busy 0, tag 0, busy_count_out=0.
- Rename x5 with tag 3, then commit x5 tag 3 data 0xDEADBEEF -> after the rename, busy=1 and tag=3 with count 1; after the commit, data=0xDEADBEEF, busy=0 and count 0.
- Rename x7 tag 2, rename x7 tag 9, commit x7 tag 2 data 0x11 -> data=0x11, busy=1, tag=9 (stale commit does not clear busy).
- Same cycle: rename x4 tag 6 and commit x4 tag 1 data 0x22 (x4 previously busy with tag 1) -> data=0x22, busy=1, tag=6.
- Rename x1, x2, x3, then flush together with rename x8 and commit x2 data 0x33 -> all busy 0, busy_count_out=0, x2=0x33, x8 not busy. Writes to x0 read back as 0.
- With REG_FILE_BYPASS_EN: commit x9 tag 4 data 0x44 while port 1 reads x9 (busy with tag 4) -> same cycle, rd_data=0x44 and rd_busy=0. Without the macro, the same stimulus gives the old value and busy=1 that cycle, and 0x44 the next cycle. Also drop rdy_in during a rename -> no state change.
